// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline sequencer.
package otter_pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_FILL,
        PC_FILL_ABORT
    } pc_state_e;

endpackage

// File: rtl/otter_hazard_unit.sv
// Combinational load-use detector: the DE instruction reads the register a load in EX will write.
module otter_hazard_unit
    import otter_pipe_pkg::*;
#(
    parameter int unsigned REG_W = otter_pipe_pkg::REG_W
) (
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    output logic             load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = de_rs1_used && (de_rs1 == ex_rd);
        rs2_hit  = de_rs2_used && (de_rs2 == ex_rd);
        // x0 is hardwired to zero, so a load targeting it never creates a dependency
        load_use = ex_mem_read && (ex_rd != REG_W'(X0)) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/otter_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage OTTER core: load/clear control and I-cache refill tracking.
// Define PIPE_PERF_EN to build the stall/flush/fill event counters; otherwise they read 0.
module otter_pipe_ctrl
    import otter_pipe_pkg::*;
#(
    parameter int unsigned REG_W = otter_pipe_pkg::REG_W,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [REG_W-1:0] de_rs1,
    input  logic [REG_W-1:0] de_rs2,
    input  logic             de_rs1_used,
    input  logic             de_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             ic_miss,
    input  logic             ic_fill_done,
    input  logic             mem_busy,
    output logic             pc_ld,
    output logic             if_de_ld,
    output logic             de_ex_ld,
    output logic             ex_mem_ld,
    output logic             mem_wb_ld,
    output logic             if_de_clr,
    output logic             de_ex_clr,
    output logic             ex_mem_clr,
    output logic             mem_wb_clr,
    output logic             ic_fill_start,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_fill
);

    pc_state_e state_q;
    pc_state_e state_d;
    logic      load_use;

    otter_hazard_unit #(
        .REG_W(REG_W)
    ) u_hazard (
        .de_rs1     (de_rs1),
        .de_rs2     (de_rs2),
        .de_rs1_used(de_rs1_used),
        .de_rs2_used(de_rs2_used),
        .ex_rd      (ex_rd),
        .ex_mem_read(ex_mem_read),
        .load_use   (load_use)
    );

    always_comb begin
        pc_ld         = 1'b1;
        if_de_ld      = 1'b1;
        de_ex_ld      = 1'b1;
        ex_mem_ld     = 1'b1;
        mem_wb_ld     = 1'b1;
        if_de_clr     = 1'b0;
        de_ex_clr     = 1'b0;
        ex_mem_clr    = 1'b0;
        mem_wb_clr    = 1'b0;
        ic_fill_start = 1'b0;
        state_d       = state_q;

        if (clr) begin
            pc_ld      = 1'b0;
            if_de_ld   = 1'b0;
            de_ex_ld   = 1'b0;
            ex_mem_ld  = 1'b0;
            mem_wb_ld  = 1'b0;
            if_de_clr  = 1'b1;
            de_ex_clr  = 1'b1;
            ex_mem_clr = 1'b1;
            mem_wb_clr = 1'b1;
            state_d    = PC_RUN;
        end else if (mem_busy) begin
            // Whole pipe frozen; branch/hazard reassert once EX moves again
            pc_ld     = 1'b0;
            if_de_ld  = 1'b0;
            de_ex_ld  = 1'b0;
            ex_mem_ld = 1'b0;
            mem_wb_ld = 1'b0;
            if (state_q != PC_RUN && ic_fill_done) begin
                state_d = PC_RUN;
            end
        end else if (ex_br_taken) begin
            if_de_ld  = 1'b0;
            de_ex_ld  = 1'b0;
            if_de_clr = 1'b1;
            de_ex_clr = 1'b1;
            if (ic_fill_done) begin
                state_d = PC_RUN;
            end else if (state_q == PC_FILL) begin
                state_d = PC_FILL_ABORT;
            end
        end else if (state_q == PC_RUN) begin
            if (load_use) begin
                pc_ld     = 1'b0;
                if_de_ld  = 1'b0;
                de_ex_ld  = 1'b0;
                de_ex_clr = 1'b1;
            end else if (ic_miss) begin
                pc_ld         = 1'b0;
                if_de_ld      = 1'b0;
                if_de_clr     = 1'b1;
                ic_fill_start = 1'b1;
                state_d       = PC_FILL;
            end
        end else begin
            pc_ld     = 1'b0;
            if_de_ld  = 1'b0;
            if_de_clr = 1'b1;
            if (ic_fill_done) begin
                state_d = PC_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= PC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;
    logic [CNT_W-1:0] fill_q;
    logic             stall_ev;
    logic             flush_ev;
    logic             fill_ev;

    always_comb begin
        stall_ev = mem_busy || (state_q == PC_RUN && !ex_br_taken && load_use);
        flush_ev = !mem_busy && ex_br_taken;
        fill_ev  = (state_q != PC_RUN);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stall_q <= '0;
            flush_q <= '0;
            fill_q  <= '0;
        end else begin
            if (stall_ev) stall_q <= stall_q + CNT_W'(1);
            if (flush_ev) flush_q <= flush_q + CNT_W'(1);
            if (fill_ev)  fill_q  <= fill_q + CNT_W'(1);
        end
    end

    assign perf_stall = stall_q;
    assign perf_flush = flush_q;
    assign perf_fill  = fill_q;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
    assign perf_fill  = '0;
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Self-checking bench for otter_pipe_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_otter_pipe_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;
`ifdef PIPE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    // {pc, if_de, de_ex, ex_mem, mem_wb loads, if_de, de_ex, ex_mem, mem_wb clears, fill_start}
    localparam logic [9:0] V_RST  = 10'b00000_1111_0;
    localparam logic [9:0] V_BUSY = 10'b00000_0000_0;
    localparam logic [9:0] V_BR   = 10'b10011_1100_0;
    localparam logic [9:0] V_LU   = 10'b00011_0100_0;
    localparam logic [9:0] V_MISS = 10'b00111_1000_1;
    localparam logic [9:0] V_WAIT = 10'b00111_1000_0;
    localparam logic [9:0] V_RUN  = 10'b11111_0000_0;

    logic             clk = 1'b0;
    logic             clr;
    logic [REG_W-1:0] de_rs1, de_rs2, ex_rd;
    logic             de_rs1_used, de_rs2_used, ex_mem_read, ex_br_taken;
    logic             ic_miss, ic_fill_done, mem_busy;
    logic             pc_ld, if_de_ld, de_ex_ld, ex_mem_ld, mem_wb_ld;
    logic             if_de_clr, de_ex_clr, ex_mem_clr, mem_wb_clr, ic_fill_start;
    logic [CNT_W-1:0] perf_stall, perf_flush, perf_fill;

    int total = 0;
    int bad   = 0;

    // Model: fetch mode 0 = running, 1 = refill pending, 2 = refill pending with line discarded
    int m_mode  = 0;
    int m_stall = 0;
    int m_flush = 0;
    int m_fill  = 0;

    logic [9:0]  got_vec, exp_vec;
    logic [11:0] got_perf, exp_perf;

    otter_pipe_ctrl #(
        .REG_W(REG_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .clr          (clr),
        .de_rs1       (de_rs1),
        .de_rs2       (de_rs2),
        .de_rs1_used  (de_rs1_used),
        .de_rs2_used  (de_rs2_used),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_br_taken  (ex_br_taken),
        .ic_miss      (ic_miss),
        .ic_fill_done (ic_fill_done),
        .mem_busy     (mem_busy),
        .pc_ld        (pc_ld),
        .if_de_ld     (if_de_ld),
        .de_ex_ld     (de_ex_ld),
        .ex_mem_ld    (ex_mem_ld),
        .mem_wb_ld    (mem_wb_ld),
        .if_de_clr    (if_de_clr),
        .de_ex_clr    (de_ex_clr),
        .ex_mem_clr   (ex_mem_clr),
        .mem_wb_clr   (mem_wb_clr),
        .ic_fill_start(ic_fill_start),
        .perf_stall   (perf_stall),
        .perf_flush   (perf_flush),
        .perf_fill    (perf_fill)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        clr          = 1'b0;
        de_rs1       = '0;
        de_rs2       = '0;
        de_rs1_used  = 1'b0;
        de_rs2_used  = 1'b0;
        ex_rd        = '0;
        ex_mem_read  = 1'b0;
        ex_br_taken  = 1'b0;
        ic_miss      = 1'b0;
        ic_fill_done = 1'b0;
        mem_busy     = 1'b0;
    endtask

    // Samples outputs at negedge, derives expectations from the rules, then steps to posedge+1.
    task automatic tick();
        logic lu, filling, lu_applied;
        int   nmode;
        @(negedge clk);
        got_vec  = {pc_ld, if_de_ld, de_ex_ld, ex_mem_ld, mem_wb_ld,
                    if_de_clr, de_ex_clr, ex_mem_clr, mem_wb_clr, ic_fill_start};
        got_perf = {perf_stall, perf_flush, perf_fill};
        exp_perf = PERF_ON ? {4'(m_stall), 4'(m_flush), 4'(m_fill)} : 12'h000;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((de_rs1_used && de_rs1 == ex_rd) || (de_rs2_used && de_rs2 == ex_rd));
        filling    = (m_mode != 0);
        lu_applied = 1'b0;
        nmode      = m_mode;
        if (clr) begin
            exp_vec = V_RST;
            nmode   = 0;
        end else if (mem_busy) begin
            exp_vec = V_BUSY;
            if (filling && ic_fill_done) nmode = 0;
        end else if (ex_br_taken) begin
            exp_vec = V_BR;
            if (ic_fill_done) nmode = 0;
            else if (m_mode == 1) nmode = 2;
        end else if (!filling && lu) begin
            exp_vec    = V_LU;
            lu_applied = 1'b1;
        end else if (!filling && ic_miss) begin
            exp_vec = V_MISS;
            nmode   = 1;
        end else if (filling) begin
            exp_vec = V_WAIT;
            if (ic_fill_done) nmode = 0;
        end else begin
            exp_vec = V_RUN;
        end
        if (clr) begin
            m_stall = 0;
            m_flush = 0;
            m_fill  = 0;
        end else begin
            if (mem_busy || lu_applied) m_stall = (m_stall + 1) % 16;
            if (!mem_busy && ex_br_taken) m_flush = (m_flush + 1) % 16;
            if (filling) m_fill = (m_fill + 1) % 16;
        end
        m_mode = nmode;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        clr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (got_vec !== V_RST) begin
                bad++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, got_vec, V_RST);
            end
        end
        clr = 1'b0;
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL reset_release: got %b want %b", got_vec, V_RUN);
        end
        total++;
        if (got_perf !== 12'h000) begin
            bad++;
            $display("FAIL reset_counters: got %h want 000", got_perf);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_mem_read = 1'b1;
        ex_rd       = 5'd5;
        de_rs2      = 5'd5;
        de_rs2_used = 1'b1;
        tick();
        total++;
        if (got_vec !== V_LU) begin
            bad++;
            $display("FAIL load_use_stall: got %b want %b", got_vec, V_LU);
        end
        ex_mem_read = 1'b0;
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL load_use_one_bubble: got %b want %b", got_vec, V_RUN);
        end
        ex_mem_read = 1'b1;
        ex_rd       = 5'd0;
        de_rs2      = 5'd0;
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL load_use_x0: got %b want %b", got_vec, V_RUN);
        end
    endtask

    task automatic test_miss();
        idle_inputs();
        ic_miss = 1'b1;
        tick();
        total++;
        if (got_vec !== V_MISS) begin
            bad++;
            $display("FAIL miss_start: got %b want %b", got_vec, V_MISS);
        end
        ic_miss = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            ic_fill_done = (i == 6);
            tick();
            total++;
            if (got_vec !== V_WAIT) begin
                bad++;
                $display("FAIL miss_fill_cycle[%0d]: got %b want %b", i, got_vec, V_WAIT);
            end
        end
        ic_fill_done = 1'b0;
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL miss_resume: got %b want %b", got_vec, V_RUN);
        end
    endtask

    task automatic test_branch_fill();
        idle_inputs();
        ic_miss = 1'b1;
        tick();
        ic_miss = 1'b0;
        tick();
        ex_br_taken = 1'b1;
        tick();
        total++;
        if (got_vec !== V_BR) begin
            bad++;
            $display("FAIL branch_in_fill: got %b want %b", got_vec, V_BR);
        end
        ex_br_taken = 1'b0;
        tick();
        total++;
        if (got_vec !== V_WAIT) begin
            bad++;
            $display("FAIL fill_abort_wait: got %b want %b", got_vec, V_WAIT);
        end
        ic_fill_done = 1'b1;
        tick();
        total++;
        if (got_vec !== V_WAIT) begin
            bad++;
            $display("FAIL fill_abort_done: got %b want %b", got_vec, V_WAIT);
        end
        ic_fill_done = 1'b0;
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL fill_abort_resume: got %b want %b", got_vec, V_RUN);
        end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        mem_busy    = 1'b1;
        ex_br_taken = 1'b1;
        ex_mem_read = 1'b1;
        ex_rd       = 5'd7;
        de_rs1      = 5'd7;
        de_rs1_used = 1'b1;
        ic_miss     = 1'b1;
        tick();
        total++;
        if (got_vec !== V_BUSY) begin
            bad++;
            $display("FAIL simul_busy: got %b want %b", got_vec, V_BUSY);
        end
        mem_busy = 1'b0;
        tick();
        total++;
        if (got_vec !== V_BR) begin
            bad++;
            $display("FAIL simul_branch_wins: got %b want %b", got_vec, V_BR);
        end
        idle_inputs();
        tick();
        total++;
        if (got_vec !== V_RUN) begin
            bad++;
            $display("FAIL simul_after: got %b want %b", got_vec, V_RUN);
        end
    endtask

    task automatic test_perf_wrap();
        logic [11:0] want;
        idle_inputs();
        clr = 1'b1;
        tick();
        clr      = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        mem_busy = 1'b0;
        tick();
        want = PERF_ON ? 12'h100 : 12'h000;
        total++;
        if (got_perf !== want) begin
            bad++;
            $display("FAIL perf_stall_wrap: got %h want %h", got_perf, want);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr          = ($urandom_range(0, 39) == 0);
            mem_busy     = ($urandom_range(0, 5) == 0);
            ex_br_taken  = ($urandom_range(0, 5) == 0);
            ic_miss      = ($urandom_range(0, 4) == 0);
            ic_fill_done = (m_mode != 0) && ($urandom_range(0, 3) == 0);
            ex_mem_read  = ($urandom_range(0, 1) == 1);
            ex_rd        = 5'($urandom_range(0, 3));
            de_rs1       = 5'($urandom_range(0, 3));
            de_rs2       = 5'($urandom_range(0, 3));
            de_rs1_used  = ($urandom_range(0, 1) == 1);
            de_rs2_used  = ($urandom_range(0, 1) == 1);
            tick();
            total++;
            if (got_vec !== exp_vec) begin
                bad++;
                $display("FAIL random_ctrl[%0d]: got %b want %b", i, got_vec, exp_vec);
            end
            total++;
            if (got_perf !== exp_perf) begin
                bad++;
                $display("FAIL random_perf[%0d]: got %h want %h", i, got_perf, exp_perf);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_miss();
        test_branch_fill();
        test_simultaneous();
        test_perf_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
